// File: rtl/esm_pkg.sv
// rtl/esm_pkg.sv - shared types and sizing helpers for the ESM dependency core
// Contents: slot_state_e slot lifecycle, BS default buffer depth, iw_of/cw_of width helpers.
package esm_pkg;

    localparam int BS = 16;

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        WAITING = 2'd1,
        ISSUED  = 2'd2
    } slot_state_e;

    // Index width for n slots; n is a power of two >= 2.
    function automatic int iw_of(input int n);
        return $clog2(n);
    endfunction

    // Occupancy count width: must represent 0..n inclusive.
    function automatic int cw_of(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/esm_rr_picker.sv
// rtl/esm_rr_picker.sv - round-robin find-first starting at a rotating pointer
// Ports: req_i request vector, ptr_i scan start, found_o any request set,
//        index_o first set request at or after ptr_i (wrapping), 0 when none.
module esm_rr_picker
    import esm_pkg::*;
#(
    parameter  int bs = BS,
    localparam int IW = iw_of(bs)
) (
    input  logic [bs-1:0] req_i,
    input  logic [IW-1:0] ptr_i,
    output logic          found_o,
    output logic [IW-1:0] index_o
);

    logic [IW-1:0] idx;

    // bs is a power of two, so IW-bit addition wraps modulo bs for free.
    always_comb begin
        found_o = 1'b0;
        index_o = '0;
        idx     = '0;
        for (int k = 0; k < bs; k++) begin
            idx = ptr_i + IW'(k);
            if (!found_o && req_i[idx]) begin
                found_o = 1'b1;
                index_o = idx;
            end
        end
    end

endmodule

// File: rtl/esm_issue_scheduler.sv
// rtl/esm_issue_scheduler.sv - slot allocator and round-robin issue scheduler
// Ports: alloc_valid/alloc_ready/alloc_index grant the lowest FREE slot to dispatch;
//        ready_index per-slot dependency-clear flags; issue_valid/issue_ready/issue_index
//        registered offer to execution; complete_valid/complete_index free ISSUED slots;
//        occupied, busy_count, err_sticky status.
module esm_issue_scheduler
    import esm_pkg::*;
#(
    parameter  int bs = BS,
    localparam int IW = iw_of(bs),
    localparam int CW = cw_of(bs)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alloc_valid,
    output logic          alloc_ready,
    output logic [IW-1:0] alloc_index,
    input  logic [bs-1:0] ready_index,
    output logic          issue_valid,
    output logic [IW-1:0] issue_index,
    input  logic          issue_ready,
    input  logic          complete_valid,
    input  logic [IW-1:0] complete_index,
    output logic [bs-1:0] occupied,
    output logic [CW-1:0] busy_count,
    output logic          err_sticky
);

    slot_state_e   state_q [bs];
    slot_state_e   state_d [bs];
    logic          issue_valid_q, issue_valid_d;
    logic [IW-1:0] issue_index_q, issue_index_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CW-1:0] busy_count_q, busy_count_d;
    logic          err_q, err_d;

    logic [bs-1:0] free_vec;
    logic [bs-1:0] eligible;
    logic [IW-1:0] pick_ptr;
    logic          pick_found;
    logic [IW-1:0] pick_index;
    logic          alloc_fire;
    logic          issue_fire;
    logic          complete_legal;

    // Lowest-index free slot; scanning downward lets the lowest hit win.
    always_comb begin
        alloc_index = '0;
        for (int i = bs - 1; i >= 0; i--) begin
            if (state_q[i] == FREE) begin
                alloc_index = IW'(i);
            end
        end
    end

    always_comb begin
        free_vec = '0;
        eligible = '0;
        occupied = '0;
        for (int i = 0; i < bs; i++) begin
            free_vec[i] = (state_q[i] == FREE);
            occupied[i] = (state_q[i] != FREE);
            // The slot currently on offer stays WAITING until accepted; exclude it
            // so it cannot be picked a second time.
            eligible[i] = (state_q[i] == WAITING) && ready_index[i] &&
                          !(issue_valid_q && (issue_index_q == IW'(i)));
        end
    end

    assign alloc_ready    = |free_vec;
    assign alloc_fire     = alloc_valid && alloc_ready;
    assign issue_fire     = issue_valid_q && issue_ready;
    // A completion for a slot being accepted this same cycle sees it still WAITING,
    // so it falls out as illegal here without a special case.
    assign complete_legal = complete_valid && (state_q[complete_index] == ISSUED);

    // On an accept the next pick must already start after the accepted slot, so the
    // picker sees the advanced pointer rather than the registered one.
    assign pick_ptr = issue_fire ? issue_index_q + IW'(1) : rr_ptr_q;

    esm_rr_picker #(.bs(bs)) u_picker (
        .req_i   (eligible),
        .ptr_i   (pick_ptr),
        .found_o (pick_found),
        .index_o (pick_index)
    );

    // Alloc, issue and legal complete always target slots in different states,
    // so the three writes never collide.
    always_comb begin
        state_d = state_q;
        if (alloc_fire) begin
            state_d[alloc_index] = WAITING;
        end
        if (issue_fire) begin
            state_d[issue_index_q] = ISSUED;
        end
        if (complete_legal) begin
            state_d[complete_index] = FREE;
        end
    end

    always_comb begin
        issue_valid_d = issue_valid_q;
        issue_index_d = issue_index_q;
        rr_ptr_d      = rr_ptr_q;
        if (!issue_valid_q || issue_ready) begin
            issue_valid_d = pick_found;
            issue_index_d = pick_index;
        end
        if (issue_fire) begin
            rr_ptr_d = issue_index_q + IW'(1);
        end
    end

    assign busy_count_d = busy_count_q + CW'(alloc_fire) - CW'(complete_legal);
    assign err_d        = err_q || (complete_valid && !complete_legal);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < bs; i++) begin
                state_q[i] <= FREE;
            end
            issue_valid_q <= 1'b0;
            issue_index_q <= '0;
            rr_ptr_q      <= '0;
            busy_count_q  <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            issue_valid_q <= issue_valid_d;
            issue_index_q <= issue_index_d;
            rr_ptr_q      <= rr_ptr_d;
            busy_count_q  <= busy_count_d;
            err_q         <= err_d;
        end
    end

    assign issue_valid = issue_valid_q;
    assign issue_index = issue_index_q;
    assign busy_count  = busy_count_q;
    assign err_sticky  = err_q;

endmodule

// File: tb/tb_esm_issue_scheduler.sv
// tb/tb_esm_issue_scheduler.sv - directed vector bench for esm_issue_scheduler (bs=4)
module tb_esm_issue_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       alloc_valid = 1'b0;
    logic       alloc_ready;
    logic [1:0] alloc_index;
    logic [3:0] ready_index = 4'h0;
    logic       issue_valid;
    logic [1:0] issue_index;
    logic       issue_ready = 1'b0;
    logic       complete_valid = 1'b0;
    logic [1:0] complete_index = 2'd0;
    logic [3:0] occupied;
    logic [2:0] busy_count;
    logic       err_sticky;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    esm_issue_scheduler #(.bs(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .alloc_valid    (alloc_valid),
        .alloc_ready    (alloc_ready),
        .alloc_index    (alloc_index),
        .ready_index    (ready_index),
        .issue_valid    (issue_valid),
        .issue_index    (issue_index),
        .issue_ready    (issue_ready),
        .complete_valid (complete_valid),
        .complete_index (complete_index),
        .occupied       (occupied),
        .busy_count     (busy_count),
        .err_sticky     (err_sticky)
    );

    typedef struct {
        logic       rst;
        logic       av;
        logic [3:0] rdy;
        logic       ir;
        logic       cv;
        logic [1:0] ci;
        logic       ar;
        logic [1:0] ai;
        logic       iv;
        logic [1:0] ii;
        logic [3:0] occ;
        logic [2:0] cnt;
        logic       err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic av, logic [3:0] rdy, logic ir, logic cv,
                                logic [1:0] ci, logic ar, logic [1:0] ai, logic iv,
                                logic [1:0] ii, logic [3:0] occ, logic [2:0] cnt, logic err);
        vec_t v;
        v.rst = r;   v.av = av;  v.rdy = rdy; v.ir = ir;   v.cv = cv;   v.ci = ci;
        v.ar  = ar;  v.ai = ai;  v.iv  = iv;  v.ii = ii;   v.occ = occ; v.cnt = cnt;
        v.err = err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic av, input logic [3:0] rdy, input logic ir,
                         input logic cv, input logic [1:0] ci);
        rst            = r;
        alloc_valid    = av;
        ready_index    = rdy;
        issue_ready    = ir;
        complete_valid = cv;
        complete_index = ci;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input vec_t v);
        chk({tag, " alloc_ready"}, 32'(alloc_ready), 32'(v.ar));
        chk({tag, " alloc_index"}, 32'(alloc_index), 32'(v.ai));
        chk({tag, " issue_valid"}, 32'(issue_valid), 32'(v.iv));
        chk({tag, " issue_index"}, 32'(issue_index), 32'(v.ii));
        chk({tag, " occupied"},    32'(occupied),    32'(v.occ));
        chk({tag, " busy_count"},  32'(busy_count),  32'(v.cnt));
        chk({tag, " err_sticky"},  32'(err_sticky),  32'(v.err));
    endtask

    initial begin
        //                rst av rdy     ir cv ci  | ar ai iv ii occ     cnt err
        vecs.push_back(mk(1, 0, 4'b0000, 0, 0, 0,    1, 0, 0, 0, 4'b0000, 0, 0)); // reset
        vecs.push_back(mk(0, 1, 4'b0000, 0, 0, 0,    1, 1, 0, 0, 4'b0001, 1, 0)); // alloc 0
        vecs.push_back(mk(0, 1, 4'b0000, 0, 0, 0,    1, 2, 0, 0, 4'b0011, 2, 0)); // alloc 1
        vecs.push_back(mk(0, 1, 4'b0000, 0, 0, 0,    1, 3, 0, 0, 4'b0111, 3, 0)); // alloc 2
        vecs.push_back(mk(0, 1, 4'b0000, 0, 0, 0,    0, 0, 0, 0, 4'b1111, 4, 0)); // alloc 3, full
        vecs.push_back(mk(0, 1, 4'b0000, 0, 0, 0,    0, 0, 0, 0, 4'b1111, 4, 0)); // full: ignored
        vecs.push_back(mk(0, 0, 4'b1111, 1, 0, 0,    0, 0, 1, 0, 4'b1111, 4, 0)); // offer 0
        vecs.push_back(mk(0, 0, 4'b1111, 1, 0, 0,    0, 0, 1, 1, 4'b1111, 4, 0)); // offer 1
        vecs.push_back(mk(0, 0, 4'b1111, 1, 0, 0,    0, 0, 1, 2, 4'b1111, 4, 0)); // offer 2
        vecs.push_back(mk(0, 0, 4'b1111, 1, 0, 0,    0, 0, 1, 3, 4'b1111, 4, 0)); // offer 3
        vecs.push_back(mk(0, 0, 4'b1111, 1, 0, 0,    0, 0, 0, 0, 4'b1111, 4, 0)); // all issued
        vecs.push_back(mk(0, 1, 4'b0000, 0, 1, 2,    1, 2, 0, 0, 4'b1011, 3, 0)); // cpl 2 + alloc blocked
        vecs.push_back(mk(0, 1, 4'b0000, 0, 1, 0,    1, 0, 0, 0, 4'b1110, 3, 0)); // alloc 2 + cpl 0
        vecs.push_back(mk(0, 1, 4'b0000, 0, 1, 1,    1, 1, 0, 0, 4'b1101, 3, 0)); // alloc 0 + cpl 1
        vecs.push_back(mk(0, 0, 4'b0000, 0, 1, 1,    1, 1, 0, 0, 4'b1101, 3, 1)); // illegal cpl 1
        vecs.push_back(mk(0, 0, 4'b0101, 0, 0, 0,    1, 1, 1, 0, 4'b1101, 3, 1)); // offer 0
        vecs.push_back(mk(0, 0, 4'b0101, 0, 0, 0,    1, 1, 1, 0, 4'b1101, 3, 1)); // stall
        vecs.push_back(mk(0, 0, 4'b0100, 0, 0, 0,    1, 1, 1, 0, 4'b1101, 3, 1)); // stall, ready drops
        vecs.push_back(mk(0, 0, 4'b0101, 1, 0, 0,    1, 1, 1, 2, 4'b1101, 3, 1)); // accept 0 -> 2
        vecs.push_back(mk(1, 0, 4'b0101, 0, 0, 0,    1, 0, 0, 0, 4'b0000, 0, 0)); // reset mid-op
        vecs.push_back(mk(0, 0, 4'b0000, 0, 0, 0,    1, 0, 0, 0, 4'b0000, 0, 0)); // idle

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].av, vecs[i].rdy, vecs[i].ir, vecs[i].cv, vecs[i].ci);
            check_all($sformatf("vec%0d", i), vecs[i]);
        end

        // Round-robin pointer wrap: accept slot 3, next scan starts at slot 0.
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 4'b0000, 0, 0, 0);
        end
        chk("wrap fill busy_count", 32'(busy_count), 32'd4);
        drive(0, 0, 4'b1000, 1, 0, 0);
        chk("wrap offer3 valid", 32'(issue_valid), 32'd1);
        chk("wrap offer3 index", 32'(issue_index), 32'd3);
        drive(0, 0, 4'b1011, 1, 0, 0);
        chk("wrap after3 valid", 32'(issue_valid), 32'd1);
        chk("wrap after3 index", 32'(issue_index), 32'd0);
        drive(0, 0, 4'b1011, 0, 0, 0);
        chk("wrap hold index", 32'(issue_index), 32'd0);
        drive(0, 0, 4'b0000, 0, 1, 3);
        chk("wrap cpl3 occupied", 32'(occupied), 32'h7);
        chk("wrap cpl3 busy_count", 32'(busy_count), 32'd3);
        chk("wrap cpl3 alloc_index", 32'(alloc_index), 32'd3);
        chk("wrap cpl3 err_sticky", 32'(err_sticky), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
